// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared state encoding, control-bit indices and payload sizing for the EX/MEM skid buffer
package ex_mem_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 0;
  function automatic int pw_of(input int dw, input int rw);
    return 2 * dw + rw + 5;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, cleared only by async active-low reset
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + {{(W-1){1'b0}}, 1'b1} : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry skid buffer at the EX/MEM boundary with registered handshakes
module ex_mem_skid
  import ex_mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_alu_out,
  input  logic          in_zero,
  input  logic [DW-1:0] in_wdata,
  input  logic [RW-1:0] in_wr_reg,
  input  logic [3:0]    in_ctrl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_alu_out,
  output logic          out_zero,
  output logic [DW-1:0] out_wdata,
  output logic [RW-1:0] out_wr_reg,
  output logic [3:0]    out_ctrl,
  output logic [CW-1:0] stall_cnt
);
  localparam int PW = pw_of(DW, RW);
  state_e state_q, state_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;
  logic out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic push, pop;
  assign in_pl = {in_alu_out, in_zero, in_wdata, in_wr_reg, in_ctrl[CTRL_REG_WRITE],
                  in_ctrl[CTRL_MEM_TO_REG], in_ctrl[CTRL_MEM_READ], in_ctrl[CTRL_MEM_WRITE]};
  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;
  // flush only drops occupancy; payload registers keep their contents
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) state_d = EMPTY;
    else
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          main_d  = in_pl;
        end
        ONE: if (push && pop) main_d = in_pl;
        else if (push) begin
          state_d = FULL;
          skid_d  = in_pl;
        end else if (pop) state_d = EMPTY;
        FULL: if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    out_valid_d = state_d != EMPTY;
    in_ready_d  = state_d != FULL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  assign {out_alu_out, out_zero, out_wdata, out_wr_reg} = main_q[PW-1:4];
  assign out_ctrl[CTRL_REG_WRITE]  = main_q[3];
  assign out_ctrl[CTRL_MEM_TO_REG] = main_q[2];
  assign out_ctrl[CTRL_MEM_READ]   = main_q[1];
  assign out_ctrl[CTRL_MEM_WRITE]  = main_q[0];
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  sat_counter #(.W(CW)) u_stall (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid_q & ~out_ready),
    .cnt  (stall_cnt)
  );
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: table vectors, corner sequences and a queue-model random run for ex_mem_skid
module tb_ex_mem_skid;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int PL = 2 * DW + RW + 5;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0, in_zero = 0;
  logic [DW-1:0] in_alu_out = '0, in_wdata = '0;
  logic [RW-1:0] in_wr_reg = '0;
  logic [3:0] in_ctrl = '0;
  logic in_ready, out_valid, out_zero;
  logic [DW-1:0] out_alu_out, out_wdata;
  logic [RW-1:0] out_wr_reg;
  logic [3:0] out_ctrl;
  logic [CW-1:0] stall_cnt;
  int pass_cnt = 0, total = 0;

  ex_mem_skid #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_out(in_alu_out), .in_zero(in_zero), .in_wdata(in_wdata), .in_wr_reg(in_wr_reg),
    .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready), .out_alu_out(out_alu_out),
    .out_zero(out_zero), .out_wdata(out_wdata), .out_wr_reg(out_wr_reg), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit iv, ordy, fl;
    bit [31:0] alu;
    bit ev, er;
    bit [31:0] ealu;
    bit [3:0] est;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PL-1:0] out_pl();
    return {out_alu_out, out_zero, out_wdata, out_wr_reg, out_ctrl};
  endfunction

  logic [PL-1:0] q[$];
  logic [PL-1:0] last_out, inpl;
  int mstall;
  bit pre_v, pre_r, mpush, mpop;

  initial begin
    tbl[0]  = '{1, 1, 0, 32'h1,  1, 1, 32'h1,  0};
    tbl[1]  = '{1, 1, 0, 32'h2,  1, 1, 32'h2,  0};
    tbl[2]  = '{1, 1, 0, 32'h3,  1, 1, 32'h3,  0};
    tbl[3]  = '{1, 1, 0, 32'h4,  1, 1, 32'h4,  0};
    tbl[4]  = '{0, 1, 0, 32'h0,  0, 1, 32'h4,  0};
    tbl[5]  = '{1, 0, 0, 32'h10, 1, 1, 32'h10, 0};
    tbl[6]  = '{1, 0, 0, 32'h20, 1, 0, 32'h10, 1};
    tbl[7]  = '{1, 0, 0, 32'h30, 1, 0, 32'h10, 2};
    tbl[8]  = '{0, 1, 0, 32'h0,  1, 1, 32'h20, 2};
    tbl[9]  = '{0, 1, 0, 32'h0,  0, 1, 32'h20, 2};
    tbl[10] = '{1, 0, 0, 32'h40, 1, 1, 32'h40, 2};
    tbl[11] = '{1, 0, 0, 32'h50, 1, 0, 32'h40, 3};
    tbl[12] = '{1, 0, 1, 32'h60, 0, 1, 32'h40, 4};
    tbl[13] = '{1, 0, 0, 32'h55, 1, 1, 32'h55, 4};
    tbl[14] = '{0, 1, 0, 32'h0,  0, 1, 32'h55, 4};
    #12 rst_n = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_alu", out_alu_out, 0);
    for (int i = 0; i < 15; i++) begin
      in_valid = tbl[i].iv; out_ready = tbl[i].ordy; flush = tbl[i].fl; in_alu_out = tbl[i].alu;
      cyc();
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].er);
      chk($sformatf("tbl%0d_alu", i), out_alu_out, tbl[i].ealu);
      chk($sformatf("tbl%0d_stall", i), stall_cnt, tbl[i].est);
    end
    flush = 0;
    in_valid = 1; out_ready = 0; in_alu_out = 32'hDEAD; in_zero = 1; in_ctrl = 4'b0001;
    in_wr_reg = 5'd17; in_wdata = 32'hCAFE;
    cyc();
    in_valid = 0; in_zero = 0; in_ctrl = 0; in_wr_reg = 0; in_wdata = 0; in_alu_out = 0;
    chk("dead_valid", out_valid, 1);
    chk("dead_alu", out_alu_out, 32'hDEAD);
    chk("dead_zero", out_zero, 1);
    chk("dead_ctrl", out_ctrl, 4'b0001);
    chk("dead_wr_reg", out_wr_reg, 5'd17);
    chk("dead_wdata", out_wdata, 32'hCAFE);
    for (int i = 0; i < (1 << CW) + 5; i++) cyc();
    chk("sat_stall", stall_cnt, 15);
    chk("sat_hold_alu", out_alu_out, 32'hDEAD);
    chk("sat_hold_valid", out_valid, 1);
    out_ready = 1;
    cyc();
    chk("sat_drain", out_valid, 0);
    in_valid = 1; out_ready = 0; in_alu_out = 32'h77;
    cyc();
    in_alu_out = 32'h88;
    cyc();
    chk("pre_rst_full", in_ready, 0);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_stall", stall_cnt, 0);
    #3 rst_n = 1;
    in_valid = 1; out_ready = 1; in_alu_out = 32'h99;
    cyc();
    in_valid = 0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_alu", out_alu_out, 32'h99);
    rst_n = 0;
    q.delete(); last_out = '0; mstall = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 11) == 0;
      in_alu_out = $urandom; in_wdata = $urandom; in_zero = $urandom_range(0, 1) == 1;
      in_wr_reg = 5'($urandom); in_ctrl = 4'($urandom);
      inpl = {in_alu_out, in_zero, in_wdata, in_wr_reg, in_ctrl};
      pre_v = q.size() > 0; pre_r = q.size() < 2;
      mpop = pre_v && out_ready; mpush = in_valid && pre_r && !flush;
      if (pre_v && !out_ready && mstall < 15) mstall++;
      if (mpop) void'(q.pop_front());
      if (flush) q.delete();
      else if (mpush) q.push_back(inpl);
      if (q.size() > 0) last_out = q[0];
      cyc();
      chk($sformatf("rnd%0d_valid", i), out_valid, q.size() > 0);
      chk($sformatf("rnd%0d_ready", i), in_ready, q.size() < 2);
      chk($sformatf("rnd%0d_stall", i), stall_cnt, mstall);
      chk($sformatf("rnd%0d_payload", i), out_pl(), last_out);
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
